// File: rtl/matmul_tb_stream_engine.sv
// Sequential C = A * B^T engine: streams A then B in, runs one MAC per cycle, and streams C out row-major.
// Define MATMUL_TB_SAT_EN to saturate results to the signed OUT_W range instead of truncating them.
module matmul_tb_stream_engine #(
  parameter int DATA_W = 16,
  parameter int M      = 4,
  parameter int N      = 4,
  parameter int K      = 8,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [OUT_W-1:0]  out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int RW = (M + N > 1) ? $clog2(M + N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, EMIT} state_t;

  state_t state, state_nx;

  logic [RW-1:0] ld_row;
  logic [KW-1:0] ld_col;
  logic [KW-1:0] k;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic          ld_last, k_last, el_last;

  // Rows 0..M-1 hold A, rows M..M+N-1 hold B, so the load stream is one linear walk.
  logic signed [DATA_W-1:0]   mem [M+N][K];
  logic signed [2*DATA_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]    acc_base;
  logic signed [ACC_W-1:0]    acc_p1;

`ifdef MATMUL_TB_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;
`endif

  function automatic logic [OUT_W-1:0] reduce_acc(input logic signed [ACC_W-1:0] v);
`ifdef MATMUL_TB_SAT_EN
    if (v > ACC_MAX) return {1'b0, {(OUT_W-1){1'b1}}};
    if (v < ACC_MIN) return {1'b1, {(OUT_W-1){1'b0}}};
`endif
    return v[OUT_W-1:0];
  endfunction

  assign ld_last = (ld_row == RW'(M + N - 1)) && (ld_col == KW'(K - 1));
  assign k_last  = (k == KW'(K - 1));
  assign el_last = (i == IW'(M - 1)) && (j == JW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: if (in_valid && ld_last) state_nx = MAC;
      MAC:  if (k_last) state_nx = EMIT;
      EMIT: if (out_ready) state_nx = el_last ? IDLE : MAC;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = (state != IDLE);
    case (state)
      LOAD: in_ready = 1'b1;
      EMIT: begin
        out_valid = 1'b1;
        out_last  = el_last;
        out_data  = reduce_acc(acc_p1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_row <= '0;
      ld_col <= '0;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ld_row <= '0;
          ld_col <= '0;
          i      <= '0;
          j      <= '0;
          k      <= '0;
        end
        LOAD: if (in_valid) begin
          if (ld_col == KW'(K - 1)) begin
            ld_col <= '0;
            ld_row <= ld_row + 1'b1;
          end else begin
            ld_col <= ld_col + 1'b1;
          end
        end
        MAC: k <= k_last ? '0 : k + 1'b1;
        EMIT: if (out_ready) begin
          if (el_last) begin
            done <= 1'b1;
          end else if (j == JW'(N - 1)) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0: one signed product of the current A/B column pair.
  assign prod_p0  = (2*DATA_W)'(mem[RW'(i)][k]) * (2*DATA_W)'(mem[RW'(M) + RW'(j)][k]);
  assign acc_base = (k == '0) ? '0 : acc_p1;

  // Stage p1: accumulator, wrapping modulo 2^ACC_W; held through EMIT so out_data stays stable.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) mem[ld_row][ld_col] <= in_data;
    if (state == MAC) acc_p1 <= acc_base + ACC_W'(prod_p0);
  end

endmodule

// File: tb/tb_matmul_tb_stream_engine.sv
// Scoreboard bench for matmul_tb_stream_engine: a plain-arithmetic model queues expected C elements, a monitor checks them.
module tb_matmul_tb_stream_engine;
  localparam int DATA_W = 16;
  localparam int M      = 4;
  localparam int N      = 4;
  localparam int K      = 8;
  localparam int ACC_W  = 40;
  localparam int OUT_W  = 32;
  localparam int JOB_LEN = (M + N) * K + M * N * (K + 1) + 1;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } exp_t;

  logic clk, rst, start, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
  logic signed [DATA_W-1:0] in_data;
  logic [OUT_W-1:0] out_data;

  matmul_tb_stream_engine #(
    .DATA_W(DATA_W), .M(M), .N(N), .K(K), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   passed = 0;
  exp_t exp_q[$];
  int   a_m [M][K];
  int   b_m [N][K];
  int   out_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   latest = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  function automatic logic [OUT_W-1:0] ref_out(input longint s);
`ifdef MATMUL_TB_SAT_EN
    longint mx;
    mx = (longint'(1) <<< (OUT_W - 1)) - 1;
    if (s > mx) return OUT_W'(mx);
    if (s < -mx - 1) return OUT_W'(-mx - 1);
`endif
    return OUT_W'(s);
  endfunction

  function automatic int rnd_elem();
    logic signed [DATA_W-1:0] r;
    r = DATA_W'($urandom);
    return int'(r);
  endfunction

  function automatic logic signed [DATA_W-1:0] beat(input int b);
    if (b < M * K) return DATA_W'(a_m[b / K][b % K]);
    return DATA_W'(b_m[(b - M * K) / K][(b - M * K) % K]);
  endfunction

  task automatic push_expected();
    longint s;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) begin
        s = 0;
        for (int x = 0; x < K; x++) s += longint'(a_m[r][x]) * longint'(b_m[c][x]);
        exp_q.push_back('{data: ref_out(s), last: (r == M - 1 && c == N - 1)});
      end
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < M; r++)
      for (int x = 0; x < K; x++)
        case (kind)
          0: a_m[r][x] = 1;
          1: a_m[r][x] = (x == r) ? 1 : 0;
          2: a_m[r][x] = -32768;
          default: a_m[r][x] = rnd_elem();
        endcase
    for (int c = 0; c < N; c++)
      for (int x = 0; x < K; x++)
        case (kind)
          0: b_m[c][x] = 2;
          1: b_m[c][x] = 10 * c + x;
          2: b_m[c][x] = -32768;
          default: b_m[c][x] = rnd_elem();
        endcase
  endtask

  task automatic wait_outs(input int target);
    int n = 0;
    while (out_cnt < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_outputs", out_cnt >= target, 1);
  endtask

  // mode: 0 plain, 1 backpressure on element 3, 2 start pulses during MAC, 3 reset during element 5
  task automatic run_job(input bit gaps, input int mode, input bit chk_len);
    int base_done, base_out, t0, n, nb;
    push_expected();
    base_done = done_cnt;
    base_out  = out_cnt;
    nb = (M + N) * K;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; in_data = beat(0); t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < nb; b++) begin
      in_valid = 1'b1; in_data = beat(b);
      @(posedge clk); #1;
      if (gaps && b < nb - 1) begin
        n = $urandom_range(0, 3);
        in_valid = 1'b0;
        for (int g = 0; g < n; g++) begin
          in_data = DATA_W'($urandom);
          start = $urandom_range(0, 1);
          @(posedge clk); #1;
        end
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (mode == 2) begin
      start = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      start = 1'b0;
    end
    if (mode == 1) begin
      wait_outs(base_out + 2);
      out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      repeat (5) begin @(posedge clk); #1; end
      out_ready = 1'b1;
    end
    if (mode == 3) begin
      wait_outs(base_out + 4);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      repeat (20) begin @(posedge clk); #1; end
      check("rst_no_done", done_cnt - base_done, 0);
      check("rst_stays_idle", busy, 0);
      return;
    end
    n = 0;
    while (done_cnt == base_done && n < 5000) begin @(posedge clk); #1; n++; end
    check("done_seen", done_cnt - base_done, 1);
    if (chk_len) check("job_length", done_cyc - t0, JOB_LEN);
    check("queue_drained", exp_q.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    check("idle_after_done", busy, 0);
    check("single_done", done_cnt - base_done, 1);
  endtask

  logic             prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0, prev_done = 1'b0, prev_rst = 1'b1;
  logic [OUT_W-1:0] prev_data = '0;
  exp_t             e;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid) check("latency", cyc - latest, K + 1);
      if (prev_valid && !prev_ready && !prev_rst) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
        end
        out_cnt++;
        latest = cyc;
      end
      if (in_valid && in_ready) latest = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
        check("valid_at_done", out_valid, 0);
      end
      if (prev_done) check("done_width", done, 0);
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    prev_done  = done;
    prev_rst   = rst;
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_out_data", out_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    fill(0); run_job(1'b0, 0, 1'b1);
    fill(1); run_job(1'b0, 0, 1'b1);
    fill(2); run_job(1'b0, 0, 1'b1);
    fill(3); run_job(1'b0, 1, 1'b0);
    fill(3); run_job(1'b1, 2, 1'b0);
    fill(0); run_job(1'b0, 3, 1'b0);
    fill(0); run_job(1'b0, 0, 1'b1);
    fill(3); run_job(1'b1, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
